// File: rtl/dm_sba.sv
// System Bus Access engine: runs single-beat sbdata0/sbaddress0 reads and writes on a req/gnt/r_valid master port.
// Latency: trigger to sbdata_valid_o is 3 cycles minimum (req 1 cycle after trigger, gnt and r_valid at earliest).
// Backpressure: master outputs are held stable until master_gnt_i; sbbusy_o stays high until the response arrives.
module dm_sba #(
   parameter int unsigned BusWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                dmactive_i,
   input  logic [BusWidth-1:0] sbaddress_i,
   input  logic                sbaddress_write_valid_i,
   input  logic                sbreadonaddr_i,
   input  logic                sbautoincrement_i,
   input  logic [2:0]          sbaccess_i,
   input  logic [BusWidth-1:0] sbdata_i,
   input  logic                sbdata_write_valid_i,
   input  logic                sbdata_read_valid_i,
   input  logic                sbreadondata_i,
   output logic [BusWidth-1:0] sbaddress_o,
   output logic [BusWidth-1:0] sbdata_o,
   output logic                sbdata_valid_o,
   output logic                sbbusy_o,
   output logic                sberror_valid_o,
   output logic [2:0]          sberror_o,
   output logic                master_req_o,
   output logic [BusWidth-1:0] master_add_o,
   output logic                master_we_o,
   output logic [BusWidth-1:0] master_wdata_o,
   output logic [3:0]          master_be_o,
   input  logic                master_gnt_i,
   input  logic                master_r_valid_i,
   input  logic [BusWidth-1:0] master_r_rdata_i,
   input  logic                master_r_err_i
);

   typedef enum logic [2:0] {
      Idle      = 3'd0,
      Read      = 3'd1,
      Write     = 3'd2,
      WaitRead  = 3'd3,
      WaitWrite = 3'd4
   } sba_state_e;

   sba_state_e          state_q, state_d;
   logic [BusWidth-1:0] addr_q, addr_d;
   logic [BusWidth-1:0] data_q, data_d;
   logic [BusWidth-1:0] wdata_q, wdata_d;
   logic [1:0]          size_q, size_d;
   logic                data_vld_q, data_vld_d;
   logic                err_vld_q, err_vld_d;
   logic [2:0]          err_q, err_d;

   // trigger decode helpers (Idle only)
   logic                trig_rd_addr, trig_wr, trig_rd_data, trig_any;
   logic [BusWidth-1:0] eff_addr;
   logic                misaligned;
   logic [BusWidth-1:0] rdata_shifted;
   logic [BusWidth-1:0] rdata_sized;

   // Decode which access (if any) fires this cycle, honouring the trigger priority.
   always_comb begin
      trig_rd_addr = sbaddress_write_valid_i && sbreadonaddr_i;
      trig_wr      = !trig_rd_addr && sbdata_write_valid_i;
      trig_rd_data = !trig_rd_addr && !sbdata_write_valid_i &&
                     sbdata_read_valid_i && sbreadondata_i;
      trig_any     = trig_rd_addr || trig_wr || trig_rd_data;
      // a same-cycle address write takes effect for the access it accompanies
      eff_addr     = sbaddress_write_valid_i ? sbaddress_i : addr_q;
      misaligned   = ((sbaccess_i == 3'd1) && eff_addr[0]) ||
                     ((sbaccess_i == 3'd2) && (eff_addr[1:0] != 2'b00));
   end

   // Align the returned word to the access lane and zero-extend to the access size.
   always_comb begin
      rdata_shifted = master_r_rdata_i >> {addr_q[1:0], 3'b000};
      rdata_sized   = '0;
      case (size_q)
         2'd0:    rdata_sized[7:0]  = rdata_shifted[7:0];
         2'd1:    rdata_sized[15:0] = rdata_shifted[15:0];
         default: rdata_sized       = rdata_shifted;
      endcase
   end

   // Next-state logic: trigger/pre-check in Idle, request handshake, response handling, abort.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      data_vld_d = 1'b0;
      err_vld_d  = 1'b0;
      err_d      = err_q;

      case (state_q)
         Idle: begin
            if (sbaddress_write_valid_i) begin
               addr_d = sbaddress_i;
            end
            if (trig_any) begin
               if (sbaccess_i > 3'd2) begin
                  err_vld_d = 1'b1;
                  err_d     = 3'd4;
               end else if (misaligned) begin
                  err_vld_d = 1'b1;
                  err_d     = 3'd3;
               end else begin
                  size_d = sbaccess_i[1:0];
                  case (sbaccess_i[1:0])
                     2'd0:    wdata_d = {4{sbdata_i[7:0]}};
                     2'd1:    wdata_d = {2{sbdata_i[15:0]}};
                     default: wdata_d = sbdata_i;
                  endcase
                  state_d = trig_wr ? Write : Read;
               end
            end
         end
         Read: begin
            if (master_gnt_i) begin
               state_d = WaitRead;
            end
         end
         Write: begin
            if (master_gnt_i) begin
               state_d = WaitWrite;
            end
         end
         WaitRead, WaitWrite: begin
            if (master_r_valid_i) begin
               state_d = Idle;
               if (master_r_err_i) begin
                  err_vld_d = 1'b1;
                  err_d     = 3'd2;
               end else begin
                  if (state_q == WaitRead) begin
                     data_d     = rdata_sized;
                     data_vld_d = 1'b1;
                  end
                  if (sbautoincrement_i) begin
                     addr_d = addr_q + (32'd1 << size_q);
                  end
               end
            end
         end
         default: state_d = Idle;
      endcase

      // dmactive low clears everything and swallows any pending pulse
      if (!dmactive_i) begin
         state_d    = Idle;
         addr_d     = '0;
         data_d     = '0;
         wdata_d    = '0;
         size_d     = 2'd0;
         data_vld_d = 1'b0;
         err_vld_d  = 1'b0;
         err_d      = 3'd0;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= Idle;
         addr_q     <= '0;
         data_q     <= '0;
         wdata_q    <= '0;
         size_q     <= 2'd0;
         data_vld_q <= 1'b0;
         err_vld_q  <= 1'b0;
         err_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wdata_q    <= wdata_d;
         size_q     <= size_d;
         data_vld_q <= data_vld_d;
         err_vld_q  <= err_vld_d;
         err_q      <= err_d;
      end
   end

   // Master port and status outputs; bus fields are zeroed while no request is pending.
   always_comb begin
      sbaddress_o     = addr_q;
      sbdata_o        = data_q;
      sbdata_valid_o  = data_vld_q;
      sberror_valid_o = err_vld_q;
      sberror_o       = err_q;
      sbbusy_o        = (state_q != Idle);
      master_req_o    = (state_q == Read) || (state_q == Write);
      master_we_o     = (state_q == Write);
      master_add_o    = '0;
      master_wdata_o  = '0;
      master_be_o     = 4'b0000;
      if (master_req_o) begin
         master_add_o   = {addr_q[31:2], 2'b00};
         master_wdata_o = wdata_q;
         case (size_q)
            2'd0:    master_be_o = 4'b0001 << addr_q[1:0];
            2'd1:    master_be_o = 4'b0011 << addr_q[1:0];
            default: master_be_o = 4'hF;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_sba.sv
// Directed bench for dm_sba with a scoreboard of expected data/error pulses.
// Inputs are driven 1ns after each rising edge; pulses are checked on falling edges.
// The bus side is a scripted responder with selectable grant delay and error.
module tb_dm_sba;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        dmactive_i;
   logic [31:0] sbaddress_i;
   logic        sbaddress_write_valid_i;
   logic        sbreadonaddr_i;
   logic        sbautoincrement_i;
   logic [2:0]  sbaccess_i;
   logic [31:0] sbdata_i;
   logic        sbdata_write_valid_i;
   logic        sbdata_read_valid_i;
   logic        sbreadondata_i;
   logic [31:0] sbaddress_o;
   logic [31:0] sbdata_o;
   logic        sbdata_valid_o;
   logic        sbbusy_o;
   logic        sberror_valid_o;
   logic [2:0]  sberror_o;
   logic        master_req_o;
   logic [31:0] master_add_o;
   logic        master_we_o;
   logic [31:0] master_wdata_o;
   logic [3:0]  master_be_o;
   logic        master_gnt_i;
   logic        master_r_valid_i;
   logic [31:0] master_r_rdata_i;
   logic        master_r_err_i;

   typedef struct {
      logic        is_err;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   errors  = 0;

   dm_sba #(.BusWidth(32)) dut (
      .clk_i                   (clk_i),
      .rst_ni                  (rst_ni),
      .dmactive_i              (dmactive_i),
      .sbaddress_i             (sbaddress_i),
      .sbaddress_write_valid_i (sbaddress_write_valid_i),
      .sbreadonaddr_i          (sbreadonaddr_i),
      .sbautoincrement_i       (sbautoincrement_i),
      .sbaccess_i              (sbaccess_i),
      .sbdata_i                (sbdata_i),
      .sbdata_write_valid_i    (sbdata_write_valid_i),
      .sbdata_read_valid_i     (sbdata_read_valid_i),
      .sbreadondata_i          (sbreadondata_i),
      .sbaddress_o             (sbaddress_o),
      .sbdata_o                (sbdata_o),
      .sbdata_valid_o          (sbdata_valid_o),
      .sbbusy_o                (sbbusy_o),
      .sberror_valid_o         (sberror_valid_o),
      .sberror_o               (sberror_o),
      .master_req_o            (master_req_o),
      .master_add_o            (master_add_o),
      .master_we_o             (master_we_o),
      .master_wdata_o          (master_wdata_o),
      .master_be_o             (master_be_o),
      .master_gnt_i            (master_gnt_i),
      .master_r_valid_i        (master_r_valid_i),
      .master_r_rdata_i        (master_r_rdata_i),
      .master_r_err_i          (master_r_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic is_err, input logic [31:0] val);
      exp_t e;
      e.is_err = is_err;
      e.val    = val;
      sb_q.push_back(e);
   endtask

   // Scripted slave: wait for req, check request fields while holding gnt low, grant, then respond.
   task automatic bus_txn(input int gnt_dly, input logic err, input logic [31:0] rdata,
                          input logic [31:0] e_add, input logic e_we, input logic [3:0] e_be,
                          input logic [31:0] e_wdata);
      int n = 0;
      while (!master_req_o && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", {31'b0, master_req_o}, 32'd1);
      for (int i = 0; i <= gnt_dly; i++) begin
         chk("req_held", {31'b0, master_req_o}, 32'd1);
         chk("add", master_add_o, e_add);
         chk("we", {31'b0, master_we_o}, {31'b0, e_we});
         chk("be", {28'b0, master_be_o}, {28'b0, e_be});
         if (e_we) chk("wdata", master_wdata_o, e_wdata);
         chk("busy_req", {31'b0, sbbusy_o}, 32'd1);
         if (i == gnt_dly) master_gnt_i = 1'b1;
         tick();
      end
      master_gnt_i = 1'b0;
      chk("req_drop", {31'b0, master_req_o}, 32'd0);
      chk("busy_wait", {31'b0, sbbusy_o}, 32'd1);
      master_r_valid_i = 1'b1;
      master_r_err_i   = err;
      master_r_rdata_i = rdata;
      tick();
      master_r_valid_i = 1'b0;
      master_r_err_i   = 1'b0;
   endtask

   // Pop the scoreboard whenever the DUT pulses read data or an error.
   always @(negedge clk_i) begin
      if (rst_ni === 1'b1) begin
         if (sbdata_valid_o && sberror_valid_o) begin
            vectors++;
            errors++;
            $error("FAIL pulse_overlap: observed both valid pulses, expected at most one");
         end else if (sbdata_valid_o || sberror_valid_o) begin
            vectors++;
            if (sb_q.size() == 0) begin
               errors++;
               $error("FAIL unexpected_pulse: observed err=%0b val=0x%08h, expected none",
                      sberror_valid_o, sberror_valid_o ? {29'b0, sberror_o} : sbdata_o);
            end else begin
               exp_t        e;
               logic [32:0] obs, exp;
               e   = sb_q.pop_front();
               obs = {sberror_valid_o, sberror_valid_o ? {29'b0, sberror_o} : sbdata_o};
               exp = {e.is_err, e.val};
               assert (obs === exp) else begin
                  errors++;
                  $error("FAIL scoreboard: observed 0x%09h expected 0x%09h", obs, exp);
               end
            end
         end
      end
   end

   initial begin
      rst_ni = 1'b0; dmactive_i = 1'b0;
      sbaddress_i = '0; sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
      sbautoincrement_i = 1'b0; sbaccess_i = 3'd2; sbdata_i = '0;
      sbdata_write_valid_i = 1'b0; sbdata_read_valid_i = 1'b0; sbreadondata_i = 1'b0;
      master_gnt_i = 1'b0; master_r_valid_i = 1'b0; master_r_rdata_i = '0; master_r_err_i = 1'b0;
      tick(); tick(); tick();

      // reset state
      chk("rst_busy", {31'b0, sbbusy_o}, 32'd0);
      chk("rst_addr", sbaddress_o, 32'd0);
      chk("rst_data", sbdata_o, 32'd0);
      chk("rst_req", {31'b0, master_req_o}, 32'd0);
      chk("rst_dvld", {31'b0, sbdata_valid_o}, 32'd0);
      chk("rst_evld", {31'b0, sberror_valid_o}, 32'd0);
      rst_ni = 1'b1; dmactive_i = 1'b1;
      tick();

      // read on address write, word, gnt one cycle late
      sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1;
      sbaddress_i = 32'h0000_1000; sbaddress_write_valid_i = 1'b1;
      push_exp(1'b0, 32'hDEAD_BEEF);
      tick();
      sbaddress_write_valid_i = 1'b0;
      chk("rd1_busy", {31'b0, sbbusy_o}, 32'd1);
      bus_txn(1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
      chk("rd1_data", sbdata_o, 32'hDEAD_BEEF);
      chk("rd1_idle", {31'b0, sbbusy_o}, 32'd0);

      // read on data read, minimum latency of 3 cycles
      sbreadondata_i = 1'b1; sbdata_read_valid_i = 1'b1;
      push_exp(1'b0, 32'h1234_5678);
      tick();
      sbdata_read_valid_i = 1'b0;
      bus_txn(0, 1'b0, 32'h1234_5678, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
      chk("rd2_latency_vld", {31'b0, sbdata_valid_o}, 32'd1);
      chk("rd2_addr_noinc", sbaddress_o, 32'h0000_1000);

      // halfword read from upper lane
      sbaccess_i = 3'd1; sbaddress_i = 32'h0000_1002; sbaddress_write_valid_i = 1'b1;
      push_exp(1'b0, 32'h0000_CAFE);
      tick();
      sbaddress_write_valid_i = 1'b0;
      bus_txn(0, 1'b0, 32'hCAFE_F00D, 32'h0000_1000, 1'b0, 4'hC, 32'h0);

      // byte read from lane 1
      sbaccess_i = 3'd0; sbaddress_i = 32'h0000_1001; sbaddress_write_valid_i = 1'b1;
      push_exp(1'b0, 32'h0000_00F0);
      tick();
      sbaddress_write_valid_i = 1'b0;
      bus_txn(2, 1'b0, 32'hCAFE_F00D, 32'h0000_1000, 1'b0, 4'h2, 32'h0);

      // byte write with autoincrement
      sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0;
      sbaddress_i = 32'h0000_1003; sbaddress_write_valid_i = 1'b1;
      tick();
      sbaddress_write_valid_i = 1'b0;
      chk("wr_noreq_addronly", {31'b0, master_req_o}, 32'd0);
      sbautoincrement_i = 1'b1; sbdata_i = 32'h0000_00A5; sbdata_write_valid_i = 1'b1;
      tick();
      sbdata_write_valid_i = 1'b0;
      bus_txn(0, 1'b0, 32'h0, 32'h0000_1000, 1'b1, 4'h8, 32'hA5A5_A5A5);
      chk("wr_autoinc", sbaddress_o, 32'h0000_1004);

      // misaligned halfword
      sbaccess_i = 3'd1; sbreadonaddr_i = 1'b1;
      sbaddress_i = 32'h0000_1001; sbaddress_write_valid_i = 1'b1;
      push_exp(1'b1, 32'd3);
      tick();
      sbaddress_write_valid_i = 1'b0;
      chk("mis_req", {31'b0, master_req_o}, 32'd0);
      chk("mis_busy", {31'b0, sbbusy_o}, 32'd0);
      tick();
      chk("mis_req2", {31'b0, master_req_o}, 32'd0);

      // unsupported size
      sbaccess_i = 3'd3; sbreadondata_i = 1'b1; sbdata_read_valid_i = 1'b1;
      push_exp(1'b1, 32'd4);
      tick();
      sbdata_read_valid_i = 1'b0;
      chk("size_req", {31'b0, master_req_o}, 32'd0);
      chk("size_busy", {31'b0, sbbusy_o}, 32'd0);
      tick();

      // bus error at top of address space: no increment
      sbaccess_i = 3'd2; sbaddress_i = 32'hFFFF_FFFC; sbaddress_write_valid_i = 1'b1;
      push_exp(1'b1, 32'd2);
      tick();
      sbaddress_write_valid_i = 1'b0;
      bus_txn(0, 1'b1, 32'h5555_5555, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0);
      chk("err_addr_keep", sbaddress_o, 32'hFFFF_FFFC);
      chk("err_data_keep", sbdata_o, 32'h0000_00F0);

      // same read succeeds: address wraps
      sbdata_read_valid_i = 1'b1;
      push_exp(1'b0, 32'h1122_3344);
      tick();
      sbdata_read_valid_i = 1'b0;
      bus_txn(0, 1'b0, 32'h1122_3344, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0);
      chk("wrap_addr", sbaddress_o, 32'h0000_0000);

      // abort in WaitRead, late response discarded
      sbautoincrement_i = 1'b0; sbreadondata_i = 1'b0;
      sbaddress_i = 32'h0000_2000; sbaddress_write_valid_i = 1'b1;
      tick();
      sbaddress_write_valid_i = 1'b0;
      chk("abort_req", {31'b0, master_req_o}, 32'd1);
      master_gnt_i = 1'b1;
      tick();
      master_gnt_i = 1'b0;
      chk("abort_waitbusy", {31'b0, sbbusy_o}, 32'd1);
      dmactive_i = 1'b0;
      tick();
      chk("abort_busy", {31'b0, sbbusy_o}, 32'd0);
      chk("abort_addr", sbaddress_o, 32'd0);
      chk("abort_data", sbdata_o, 32'd0);
      dmactive_i = 1'b1;
      master_r_valid_i = 1'b1; master_r_rdata_i = 32'h7777_7777;
      tick();
      master_r_valid_i = 1'b0;
      chk("late_rvalid", {31'b0, sbdata_valid_o}, 32'd0);
      tick();
      chk("late_data", sbdata_o, 32'd0);
      tick(); tick();

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dm_sba.md
Name: dm_sba

Overview:
- System Bus Access engine of the debug module, directly downstream of the DM register file.
- Consumes decoded sbcs/sbaddress0/sbdata0 accesses from the DM CSR block.
- Executes single-beat reads and writes on a 32-bit req/gnt/r_valid system-bus master port.
- Returns read data, busy status, error codes and the (auto-incremented) address to the CSR block.

Parameters:
- BusWidth, 32, system-bus address/data width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- dmactive_i  in  1  dmcontrol.dmactive; low aborts and idles the engine
- sbaddress_i  in  32  new sbaddress0 value from the CSR block
- sbaddress_write_valid_i  in  1  debugger wrote sbaddress0 (1-cycle pulse)
- sbreadonaddr_i  in  1  sbcs.sbreadonaddr
- sbautoincrement_i  in  1  sbcs.sbautoincrement
- sbaccess_i  in  3  sbcs.sbaccess (0=8b, 1=16b, 2=32b)
- sbdata_i  in  32  sbdata0 write value
- sbdata_write_valid_i  in  1  debugger wrote sbdata0 (pulse)
- sbdata_read_valid_i  in  1  debugger read sbdata0 (pulse)
- sbreadondata_i  in  1  sbcs.sbreadondata
- sbaddress_o  out  32  current address register
- sbdata_o  out  32  last read data, zero-extended
- sbdata_valid_o  out  1  1-cycle pulse when sbdata_o updates
- sbbusy_o  out  1  sbcs.sbbusy
- sberror_valid_o  out  1  1-cycle pulse with sberror_o
- sberror_o  out  3  sberror code (2 bad address/bus error, 3 alignment, 4 unsupported size)
- master_req_o  out  1  bus request
- master_add_o  out  32  bus address
- master_we_o  out  1  1 = write
- master_wdata_o  out  32  write data
- master_be_o  out  4  byte enables
- master_gnt_i  in  1  request accepted
- master_r_valid_i  in  1  response valid
- master_r_rdata_i  in  32  read data
- master_r_err_i  in  1  response error, qualified by r_valid

Behaviour:
- Reset: all regs and outputs 0. State = Idle.
- State machine, using the DM sba_state_e encoding: Idle, Read, Write, WaitRead, WaitWrite.
- sbbusy_o = (state != Idle).
- Address register:
  - Loaded from sbaddress_i on sbaddress_write_valid_i, in Idle only.
  - In other states the write is ignored; the CSR block flags sbbusyerror.
- Idle trigger priority (highest first):
  1. sbaddress_write_valid_i && sbreadonaddr_i -> read, using the new address.
  2. sbdata_write_valid_i -> write.
  3. sbdata_read_valid_i && sbreadondata_i -> read.
- Pre-checks in the trigger cycle, in order:
  - sbaccess_i > 2 -> sberror_valid_o, sberror_o=4, stay Idle.
  - Misalignment (sbaccess 1 with addr[0]; sbaccess 2 with addr[1:0] != 0) -> sberror_o=3, stay Idle.
  - No bus request is issued in either case.
- Read / Write states:
  - master_req_o=1; master_add_o = {addr[31:2], 2'b00}; master_we_o = 1 in Write.
  - Hold all master outputs stable until master_gnt_i.
  - On gnt, drop req the same edge and go to WaitRead / WaitWrite.
  - First req cycle is 1 clock after the trigger.
- master_be_o:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << addr[1:0]
  - size 2: 4'hF
- master_wdata_o: byte replicated x4 (size 0), halfword replicated x2 (size 1), full word (size 2).
- WaitRead, on master_r_valid_i:
  - r_err=0: sbdata_o = (rdata >> 8*addr[1:0]) masked to the access size; sbdata_valid_o pulses.
  - r_err=1: sberror_o=2 with pulse; sbdata_o unchanged.
  - Go Idle.
- WaitWrite, on master_r_valid_i: error handling as for reads; go Idle.
- Auto-increment:
  - On a successful response with sbautoincrement_i=1: sbaddress_o += (1 << sbaccess); wraps modulo 2^32.
  - No increment on error.
- Minimum latency: trigger to sbdata_valid_o = 3 cycles (gnt and r_valid each in the first possible cycle).
- dmactive_i low:
  - Synchronous abort to Idle; req deasserted.
  - Address and data registers cleared; error pulse suppressed.
  - A master_r_valid_i arriving in Idle is discarded.
- Error outputs and sbdata_valid_o are never asserted in the same cycle.

Test Plan:
- Write 0x1000 with sbreadonaddr=1, sbaccess=2; gnt after 1 cycle, r_valid with rdata 0xDEADBEEF -> req with add 0x1000, be 0xF; sbdata_o=0xDEADBEEF, valid pulse; sbbusy_o high from trigger until response cycle.
- sbaccess=0, addr 0x1003, sbdata write 0xA5, autoincrement=1 -> we=1, be=0x8, wdata=0xA5A5A5A5; sbaddress_o becomes 0x1004 after response.
- sbaccess=1, addr 0x1001, read trigger -> sberror_o=3 pulse, no master_req_o, sbbusy_o stays 0.
- sbaccess=3 -> sberror_o=4 pulse, no bus traffic.
- Read with r_err=1 at addr 0xFFFFFFFC, autoincrement=1 -> sberror_o=2, sbaddress_o unchanged; repeat with r_err=0 -> address wraps to 0x00000000.
- dmactive_i dropped while in WaitRead -> next cycle state Idle, sbbusy_o=0; late r_valid produces no sbdata_valid_o.
